// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: holds HI/LO, runs a fixed-latency busy counter, raises MDStall.
// Optional build macro MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (9..12).
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DIsMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        MDStall
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_pwr;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic        w_madd;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_long;
  logic        w_signed;
  logic        w_go;
  logic [3:0]  w_cycles;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [63:0] w_mul_res;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [63:0] w_result;

`ifdef MD_MADD_EN
  logic        w_sub;
  logic [63:0] w_acc;
  assign w_madd    = (Op >= OP_MADD) && (Op <= OP_MSUBU);
  assign w_sub     = (Op == OP_MSUB) || (Op == OP_MSUBU);
  assign w_acc     = {r_hi, r_lo};
  assign w_mul_res = w_madd ? (w_sub ? (w_acc - w_prod) : (w_acc + w_prod)) : w_prod;
`else
  assign w_madd    = 1'b0;
  assign w_mul_res = w_prod;
`endif

  assign w_is_mul = (Op == OP_MULT) || (Op == OP_MULTU) || w_madd;
  assign w_is_div = (Op == OP_DIV) || (Op == OP_DIVU);
  assign w_long   = w_is_mul || w_is_div;
  assign w_signed = (Op == OP_MULT) || (Op == OP_DIV) ||
                    (w_madd && ((Op == OP_MADD) || (Op == OP_MSUB)));
  assign w_go     = Start && !Req && !r_busy;
  assign w_cycles = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  // Sign/zero extension to 64 bits makes the low 64 product bits right for both signednesses.
  assign w_a_ext = {{32{w_signed & A[31]}}, A};
  assign w_b_ext = {{32{w_signed & B[31]}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes: one unsigned divider, and no INT_MIN/-1 trap.
  assign w_a_neg  = w_signed & A[31];
  assign w_b_neg  = w_signed & B[31];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_uq     = w_a_mag / w_b_safe;
  assign w_ur     = w_a_mag % w_b_safe;
  assign w_quo    = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_rem    = w_a_neg ? -w_ur : w_ur;

  assign w_result = w_is_div ? {w_rem, w_quo} : w_mul_res;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_phi   <= 32'd0;
      r_plo   <= 32'd0;
      r_pwr   <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            if (w_long) begin
              r_phi   <= w_result[63:32];
              r_plo   <= w_result[31:0];
              r_pwr   <= !(w_is_div && (B == 32'd0));
              r_cnt   <= w_cycles;
              r_busy  <= 1'b1;
              r_state <= S_BUSY;
            end else if (Op == OP_MTHI) begin
              r_hi <= A;
            end else if (Op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_pwr) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign Busy    = r_busy;
  assign MDStall = DIsMD && ((Start && w_long) || r_busy);
  assign RdData  = (Op == OP_MFHI) ? r_hi :
                   (Op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: arithmetic, latency, stall, Req blocking, async reset and accumulate ops.
module tb_md_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        DIsMD = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] RdData;
  logic        Busy;
  logic        MDStall;

  int n_checks = 0;
  int n_errors = 0;
  int n_viol = 0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Start(Start), .Op(Op), .A(A), .B(B),
    .DIsMD(DIsMD), .HI(HI), .LO(LO), .RdData(RdData), .Busy(Busy), .MDStall(MDStall)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Start && Busy) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op, count busy cycles (bounded), then check latency, stall and HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cnt = 0;
    int stl = 0;
    int early = 0;
    logic [31:0] hi0 = HI;
    logic [31:0] lo0 = LO;
    Start = 1'b1; Op = op; A = a; B = b; DIsMD = 1'b0;
    tick();
    Start = 1'b0; Op = 4'd0; DIsMD = dmd;
    #1;
    while (Busy && cnt < 20) begin
      cnt++;
      if (MDStall) stl++;
      if (HI !== hi0 || LO !== lo0) early++;
      tick();
    end
    check({tag, "_busy"}, 32'(cnt), 32'(exp_busy));
    check({tag, "_early"}, 32'(early), 32'd0);
    if (dmd) begin
      check({tag, "_stallcnt"}, 32'(stl), 32'(exp_busy));
      check({tag, "_stall_after"}, {31'd0, MDStall}, 32'd0);
    end
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
    DIsMD = 1'b0;
    $display("%s op=%0d A=%h B=%h busy=%0d HI=%h LO=%h", tag, op, a, b, cnt, HI, LO);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_stall", {31'd0, MDStall}, 32'd0);
    Reset = 1'b0;
    tick();

    run_op("mult",  4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_nb", 4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",  4'd4, 32'd100, 32'd7, 1'b0, 10, 32'h00000002, 32'h0000000E);
    run_op("divu0", 4'd4, 32'd5, 32'd0, 1'b0, 10, 32'h00000002, 32'h0000000E);

    run_op("mult_stall", 4'd1, 32'h00010003, 32'h00020000, 1'b1, 5, 32'h00000002, 32'h00060000);
    Op = 4'd8; #1;
    check("rd_mflo", RdData, 32'h00060000);
    Op = 4'd7; #1;
    check("rd_mfhi", RdData, 32'h00000002);
    Op = 4'd0; #1;
    check("rd_none", RdData, 32'd0);

    // Req blocks the start; the stall term itself does not look at Req.
    Start = 1'b1; Op = 4'd3; A = 32'd100; B = 32'd3; Req = 1'b1; DIsMD = 1'b1; #1;
    check("req_stall_dmd", {31'd0, MDStall}, 32'd1);
    DIsMD = 1'b0; #1;
    check("req_stall_nodmd", {31'd0, MDStall}, 32'd0);
    tick();
    Start = 1'b0; Req = 1'b0; Op = 4'd0; #1;
    check("req_busy", {31'd0, Busy}, 32'd0);
    check("req_hi", HI, 32'h00000002);
    check("req_lo", LO, 32'h00060000);
    $display("req_blocked op=3 busy=%0d HI=%h LO=%h", Busy, HI, LO);

    Start = 1'b1; Op = 4'd5; DIsMD = 1'b1; #1;
    check("mthi_nostall", {31'd0, MDStall}, 32'd0);
    Start = 1'b0; DIsMD = 1'b0;
    run_op("mthi", 4'd5, 32'h12345678, 32'd0, 1'b0, 0, 32'h12345678, 32'h00060000);
    run_op("mtlo", 4'd6, 32'hCAFEF00D, 32'd0, 1'b0, 0, 32'h12345678, 32'hCAFEF00D);
    run_op("op13", 4'd13, 32'd9, 32'd9, 1'b0, 0, 32'h12345678, 32'hCAFEF00D);

    // Async reset three cycles into a divide: cleared before the next edge, no late commit.
    Start = 1'b1; Op = 4'd3; A = 32'd1000; B = 32'd7;
    tick();
    Start = 1'b0; Op = 4'd0;
    tick();
    tick();
    Reset = 1'b1; #1;
    check("arst_busy", {31'd0, Busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    tick();
    Reset = 1'b0;
    repeat (12) tick();
    check("arst_late_busy", {31'd0, Busy}, 32'd0);
    check("arst_late_hi", HI, 32'd0);
    check("arst_late_lo", LO, 32'd0);
    $display("async_reset_mid_div busy=%0d HI=%h LO=%h", Busy, HI, LO);

    run_op("mtlo_ff", 4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
    run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b1, 5, 32'h00000001, 32'h00000000);
    run_op("msub",  4'd11, 32'd2, 32'd1, 1'b0, 5, 32'h00000000, 32'hFFFFFFFE);
    run_op("madd",  4'd9, 32'hFFFFFFFF, 32'd3, 1'b0, 5, 32'h00000000, 32'hFFFFFFFB);
`else
    Start = 1'b1; Op = 4'd10; DIsMD = 1'b1; #1;
    check("maddu_nostall", {31'd0, MDStall}, 32'd0);
    Start = 1'b0; DIsMD = 1'b0;
    run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF);
`endif

    check("no_start_busy", 32'(n_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencing controller for the multiply/divide resource in the 5-stage MIPS pipeline; sits in E stage beside the ALU.
- Accepts one MD operation per start from E, holds HI/LO, and runs a fixed-latency busy counter.
- Generates MDStall to freeze F/D when a D-stage MD-class instruction meets an in-flight or starting operation.
- Suppresses starts on exception Req so a flushed E-stage instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  1  exception/interrupt request from M stage; blocks any start this cycle.
- Start  input  1  E-stage instruction is an MD operation (valid qualifier for Op).
- Op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- DIsMD  input  1  D-stage instruction is any MD-class op (1..12).
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- RdData  output  32  combinational: HI when Op=MFHI, LO when Op=MFLO, else 0.
- Busy  output  1  operation in flight.
- MDStall  output  1  stall request to D_REG/PC.

Behaviour:
- Reset (async, any time including mid-operation): HI=0, LO=0, Busy=0, counter=0, pending results=0, state IDLE. MDStall is therefore 0 unless Start && DIsMD.
- Effective start: go = Start && !Req && !Busy. Starts while Busy are ignored; the stall guarantees they do not occur, and the bench asserts this.
- States:
  - IDLE: on go with MULT/MULTU/DIV/DIVU (or madd family when enabled), compute the result combinationally, latch it into pending {phi, plo}, load counter with N, go to BUSY. On go with MTHI/MTLO, write A to HI/LO at this edge and stay in IDLE. MFHI/MFLO/NONE cause no state change.
  - BUSY: counter decrements each edge. On the edge where counter==1, commit pending to HI/LO and go to IDLE.
- Latency: go sampled at edge t; Busy=1 for exactly N cycles after t; new HI/LO visible at cycle t+N+1; Busy=0 in that same cycle.
- Arithmetic:
  - MULT: signed 32x32->64, {HI,LO}=product.
  - MULTU: unsigned 32x32->64.
  - DIV: signed, LO=quotient, HI=remainder (sign of dividend, truncation toward zero).
  - DIVU: unsigned division.
  - Divide by zero: still busy DIV_CYCLES; HI/LO unchanged at commit.
- Req arriving while BUSY does not cancel the in-flight operation (already past commit point); it only blocks new starts.
- MDStall = DIsMD && ((Start && (Op in 1..4, or 9..12 when enabled)) || Busy). Purely combinational; MTHI/MTLO/MF* in E do not stall D.
- Ops 13..15 are treated as NONE.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops 9..12 are legal. MADD: {HI,LO} += signed A*B. MADDU: unsigned accumulate. MSUB/MSUBU: subtract. The pre-start {HI,LO} is latched at go. Latency is MULT_CYCLES, and these ops raise MDStall like MULT.
- Undefined: ops 9..12 behave as NONE (no busy, no write, no stall contribution).

Test Plan:
- Reset released; Start=1, Op=MULT, A=0xFFFFFFFE, B=3 -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with B=0 -> Busy 10 cycles, HI/LO unchanged.
- MULT starts, then DIsMD=1 (MFLO in D) for every busy cycle -> MDStall=1 each cycle; MDStall=0 in the commit-visible cycle; RdData with Op=MFLO returns new LO.
- Start=1, Op=DIV, Req=1 same cycle -> Busy stays 0, HI/LO unchanged, MDStall=0 with DIsMD=0; MTHI A=0x12345678 with Req=0 -> HI=0x12345678 next cycle, Busy=0.
- Reset asserted 3 cycles into a DIV -> Busy, HI and LO go to 0 immediately (asynchronously), no later commit occurs.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro, same stimulus -> no Busy, HI/LO unchanged.
